// File: rtl/intp_scheduler.sv
`default_nettype none
// ============================================================================
// intp_scheduler : latches interrupt requests, grants the highest-priority
//                  pending source to the processor and holds it until ack or
//                  service timeout.
// Revision       : 1.0
// ============================================================================
module intp_scheduler #(
   parameter int NUM_OF_PERIPHERALS = 16,
   parameter int ID_WIDTH           = 4,
   parameter int PRIO_WIDTH         = 4,
   parameter int SVC_TIMEOUT        = 256
) (
   input  logic                                     pclk_i,
   input  logic                                     prstn_i,
   input  logic [NUM_OF_PERIPHERALS-1:0]            intp_active_i,
   input  logic [NUM_OF_PERIPHERALS-1:0]            intp_mask_i,
   input  logic [NUM_OF_PERIPHERALS*PRIO_WIDTH-1:0] prio_flat_i,
   input  logic                                     intp_serviced_i,
   output logic                                     intp_valid_o,
   output logic [ID_WIDTH-1:0]                      intp_to_service_o,
   output logic [NUM_OF_PERIPHERALS-1:0]            intp_pending_o,
   output logic                                     intp_timeout_o
);

   localparam int               CNT_W      = $clog2(SVC_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SVC_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARB   = 2'd1,
      ST_GRANT = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic [NUM_OF_PERIPHERALS-1:0]   r_pend;
   logic [NUM_OF_PERIPHERALS-1:0]   w_pend_nxt;
   logic [NUM_OF_PERIPHERALS-1:0]   w_set;
   logic [NUM_OF_PERIPHERALS-1:0]   w_elig;
   logic [NUM_OF_PERIPHERALS-1:0]   w_clr;
   logic [ID_WIDTH-1:0]             r_id;
   logic [ID_WIDTH-1:0]             w_id_nxt;
   logic [ID_WIDTH-1:0]             w_win_id;
   logic [PRIO_WIDTH-1:0]           w_win_prio;
   logic [CNT_W-1:0]                r_cnt;
   logic [CNT_W-1:0]                w_cnt_nxt;
   logic                            r_valid;
   logic                            w_valid_nxt;
   logic                            r_tout;
   logic                            w_tout_nxt;

   // A zero priority field disables the source for both latching and arbitration.
   for (genvar k = 0; k < NUM_OF_PERIPHERALS; k++) begin : g_src
      logic w_prio_nz;
      assign w_prio_nz = |prio_flat_i[k*PRIO_WIDTH +: PRIO_WIDTH];
      assign w_set[k]  = intp_active_i[k] & ~intp_mask_i[k] & w_prio_nz;
      assign w_elig[k] = r_pend[k]        & ~intp_mask_i[k] & w_prio_nz;
   end

   // Strict greater-than while scanning upward keeps the lowest index on ties.
   always_comb begin
      w_win_id   = '0;
      w_win_prio = '0;
      for (int k = 0; k < NUM_OF_PERIPHERALS; k++) begin
         if (w_elig[k] && (prio_flat_i[k*PRIO_WIDTH +: PRIO_WIDTH] > w_win_prio)) begin
            w_win_prio = prio_flat_i[k*PRIO_WIDTH +: PRIO_WIDTH];
            w_win_id   = ID_WIDTH'(k);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_id_nxt    = r_id;
      w_cnt_nxt   = r_cnt;
      w_tout_nxt  = 1'b0;
      w_clr       = '0;
      case (r_state)
         ST_IDLE: begin
            if (|w_elig) begin
               w_state_nxt = ST_ARB;
            end
         end
         ST_ARB: begin
            if (|w_elig) begin
               w_id_nxt    = w_win_id;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_GRANT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (intp_serviced_i) begin
               w_state_nxt = ST_CLEAR;
            end else if (r_cnt == C_CNT_LAST) begin
               w_state_nxt = ST_CLEAR;
               w_tout_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_CLEAR: begin
            w_clr[r_id] = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // A simultaneous new request wins over the retire clear.
      w_pend_nxt  = (r_pend & ~w_clr) | w_set;
      w_valid_nxt = (w_state_nxt == ST_GRANT);
   end

   always_ff @(posedge pclk_i or negedge prstn_i) begin
      if (!prstn_i) begin
         r_state <= ST_IDLE;
         r_pend  <= '0;
         r_id    <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_tout  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         r_id    <= w_id_nxt;
         r_cnt   <= w_cnt_nxt;
         r_valid <= w_valid_nxt;
         r_tout  <= w_tout_nxt;
      end
   end

   assign intp_valid_o      = r_valid;
   assign intp_to_service_o = r_id;
   assign intp_pending_o    = r_pend;
   assign intp_timeout_o    = r_tout;

endmodule
`default_nettype wire

// File: tb/tb_intp_scheduler.sv
`default_nettype none
// ============================================================================
// tb_intp_scheduler : directed and randomized checks of intp_scheduler
//                     against a behavioural model.
// Revision          : 1.0
// ============================================================================
module tb_intp_scheduler;

   localparam int N  = 16;
   localparam int PW = 4;
   localparam int T  = 8;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  act;
   logic [N-1:0]  msk;
   logic [N*PW-1:0] prio;
   logic          svc;
   logic          dut_valid;
   logic [3:0]    dut_id;
   logic [N-1:0]  dut_pend;
   logic          dut_tout;

   int n_vec;
   int n_fail;

   // model state: phase 0=idle,1=arbitrate,2=granted,3=retire
   int            m_phase;
   logic [N-1:0]  m_pend;
   int            m_id;
   int            m_age;
   bit            m_valid;
   bit            m_tout;

   intp_scheduler #(
      .NUM_OF_PERIPHERALS(N),
      .ID_WIDTH          (4),
      .PRIO_WIDTH        (PW),
      .SVC_TIMEOUT       (T)
   ) dut (
      .pclk_i           (clk),
      .prstn_i          (rst_n),
      .intp_active_i    (act),
      .intp_mask_i      (msk),
      .prio_flat_i      (prio),
      .intp_serviced_i  (svc),
      .intp_valid_o     (dut_valid),
      .intp_to_service_o(dut_id),
      .intp_pending_o   (dut_pend),
      .intp_timeout_o   (dut_tout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_vec++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   function automatic int prio_of(input int k);
      return int'(prio[k*PW +: PW]);
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_pend  = '0;
      m_id    = 0;
      m_age   = 0;
      m_valid = 0;
      m_tout  = 0;
   endtask

   // Advance the model across one rising edge using the inputs now applied.
   task automatic model_step();
      logic [N-1:0] setv;
      logic [N-1:0] elig;
      logic [N-1:0] clr;
      int           win;
      setv = '0;
      elig = '0;
      clr  = '0;
      for (int k = 0; k < N; k++) begin
         setv[k] = act[k] && !msk[k] && (prio_of(k) != 0);
         elig[k] = m_pend[k] && !msk[k] && (prio_of(k) != 0);
      end
      win = -1;
      for (int p = 15; p >= 1 && win < 0; p--)
         for (int k = 0; k < N && win < 0; k++)
            if (elig[k] && prio_of(k) == p) win = k;
      m_tout = 0;
      case (m_phase)
         0: if (elig != 0) m_phase = 1;
         1: begin
            if (win >= 0) begin
               m_id    = win;
               m_age   = 0;
               m_phase = 2;
            end else begin
               m_phase = 0;
            end
         end
         2: begin
            if (svc) m_phase = 3;
            else if (m_age == T - 1) begin
               m_phase = 3;
               m_tout  = 1;
            end else m_age++;
         end
         default: begin
            clr[m_id] = 1'b1;
            m_phase   = 0;
         end
      endcase
      m_pend  = (m_pend & ~clr) | setv;
      m_valid = (m_phase == 2);
   endtask

   task automatic compare_all();
      chk("valid",   32'(dut_valid), 32'(m_valid));
      chk("id",      32'(dut_id),    32'(m_id));
      chk("pending", 32'(dut_pend),  32'(m_pend));
      chk("timeout", 32'(dut_tout),  32'(m_tout));
   endtask

   task automatic cycle(input logic [N-1:0] a, input logic s);
      act = a;
      svc = s;
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_valid(input logic [N-1:0] a);
      for (int i = 0; i < 12; i++) begin
         if (dut_valid) break;
         cycle(a, 1'b0);
      end
      chk("grant_seen", 32'(dut_valid), 32'd1);
   endtask

   task automatic set_prio(input int k, input int v);
      prio[k*PW +: PW] = PW'(v);
   endtask

   initial begin
      int k;
      n_vec  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      act    = '0;
      msk    = '0;
      prio   = '0;
      svc    = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_valid",   32'(dut_valid), 32'd0);
      chk("rst_id",      32'(dut_id),    32'd0);
      chk("rst_pending", 32'(dut_pend),  32'd0);
      chk("rst_timeout", 32'(dut_tout),  32'd0);
      rst_n = 1'b1;

      // single request, three edges to grant
      set_prio(5, 3);
      cycle(16'h0020, 1'b0);
      chk("single_pend", 32'(dut_pend), 32'h0020);
      chk("single_novalid", 32'(dut_valid), 32'd0);
      cycle(16'h0000, 1'b0);
      chk("single_arb_novalid", 32'(dut_valid), 32'd0);
      cycle(16'h0000, 1'b0);
      chk("single_valid", 32'(dut_valid), 32'd1);
      chk("single_id", 32'(dut_id), 32'd5);
      cycle(16'h0000, 1'b1);
      chk("single_ack_valid", 32'(dut_valid), 32'd0);
      cycle(16'h0000, 1'b0);
      chk("single_pend_clr", 32'(dut_pend[5]), 32'd0);

      // priority and tie order, then no preemption
      set_prio(2, 7);
      set_prio(9, 7);
      set_prio(12, 4);
      cycle(16'h1204, 1'b0);
      wait_valid('0);
      chk("tie_first", 32'(dut_id), 32'd2);
      cycle('0, 1'b1);
      wait_valid('0);
      chk("tie_second", 32'(dut_id), 32'd9);
      cycle('0, 1'b1);
      wait_valid('0);
      chk("prio_third", 32'(dut_id), 32'd12);
      set_prio(3, 9);
      cycle(16'h0008, 1'b0);
      repeat (3) cycle('0, 1'b0);
      chk("nopreempt_valid", 32'(dut_valid), 32'd1);
      chk("nopreempt_id", 32'(dut_id), 32'd12);
      cycle('0, 1'b1);
      wait_valid('0);
      chk("after_preempt_id", 32'(dut_id), 32'd3);
      cycle('0, 1'b1);

      // masked and disabled sources
      msk = 16'h0080;
      set_prio(7, 5);
      set_prio(8, 0);
      cycle(16'h0180, 1'b0);
      cycle(16'h0180, 1'b0);
      chk("masked_pend", 32'(dut_pend[7]), 32'd0);
      chk("prio0_pend", 32'(dut_pend[8]), 32'd0);
      repeat (4) cycle('0, 1'b0);
      chk("masked_nogrant", 32'(dut_valid), 32'd0);
      msk = '0;

      // timeout after eight grant cycles
      set_prio(6, 2);
      cycle(16'h0040, 1'b0);
      wait_valid('0);
      chk("to_id", 32'(dut_id), 32'd6);
      k = 0;
      for (int i = 0; i < 20; i++) begin
         cycle('0, 1'b0);
         k++;
         if (dut_tout) break;
      end
      chk("to_cycles", 32'(k), 32'd8);
      chk("to_pulse", 32'(dut_tout), 32'd1);
      chk("to_valid_low", 32'(dut_valid), 32'd0);
      cycle('0, 1'b0);
      chk("to_pulse_end", 32'(dut_tout), 32'd0);
      chk("to_pend_clr", 32'(dut_pend[6]), 32'd0);

      // ack on the last grant cycle beats the timeout
      cycle(16'h0040, 1'b0);
      wait_valid('0);
      repeat (7) cycle('0, 1'b0);
      chk("last_cycle_valid", 32'(dut_valid), 32'd1);
      cycle('0, 1'b1);
      chk("ack_wins_tout", 32'(dut_tout), 32'd0);
      chk("ack_wins_valid", 32'(dut_valid), 32'd0);
      cycle('0, 1'b0);

      // held request re-pends and is granted again
      set_prio(4, 5);
      cycle(16'h0010, 1'b0);
      wait_valid(16'h0010);
      chk("repend_id", 32'(dut_id), 32'd4);
      cycle(16'h0010, 1'b1);
      cycle(16'h0010, 1'b0);
      chk("repend_bit", 32'(dut_pend[4]), 32'd1);
      wait_valid(16'h0010);
      chk("regrant_id", 32'(dut_id), 32'd4);
      cycle('0, 1'b1);
      cycle('0, 1'b0);
      chk("repend_release", 32'(dut_pend[4]), 32'd0);

      // asynchronous reset in the middle of a grant
      cycle(16'h0020, 1'b0);
      wait_valid('0);
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(dut_valid), 32'd0);
      chk("async_id", 32'(dut_id), 32'd0);
      chk("async_pending", 32'(dut_pend), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (c % 50 == 0)
            for (int j = 0; j < N; j++)
               prio[j*PW +: PW] = ($urandom_range(0, 3) == 0) ? 4'd0 : PW'($urandom_range(1, 15));
         if ($urandom_range(0, 15) == 0)
            msk = N'($urandom & $urandom & $urandom);
         cycle(N'($urandom & $urandom & $urandom), ($urandom_range(0, 5) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
